// File: rtl/seg_scan_display_pkg.sv
// Shared definitions for the seven-segment scan display: segment patterns,
// converter FSM states and the BCD nibble helper.
package seg_scan_display_pkg;

  localparam int NIB_W      = 4;
  localparam int BCD_DIGITS = 10;
  localparam int BCD_W      = NIB_W * BCD_DIGITS;

  // Active-low patterns, bit 6 = segment a ... bit 0 = segment g.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Shift-add-3 correction applied to every nibble before each shift.
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (bcd[k*NIB_W +: NIB_W] >= 4'd5) begin
        res[k*NIB_W +: NIB_W] = bcd[k*NIB_W +: NIB_W] + 4'd3;
      end else begin
        res[k*NIB_W +: NIB_W] = bcd[k*NIB_W +: NIB_W];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_scan_display_decode.sv
// Combinational BCD nibble to active-low seven-segment decoder.
module bcd_seg_decode
  import seg_scan_display_pkg::*;
(
  input  logic [NIB_W-1:0] nib_i,
  output logic [6:0]       seg_o
);

  // Values above 9 are not produced by the converter and show as blank.
  always_comb begin
    seg_o = SEG_BLANK;
    case (nib_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// Decimal display of a 32-bit word on a multiplexed common-anode bank:
// sequential binary-to-BCD conversion, atomic display register and digit scan.
module seg_scan_display
  import seg_scan_display_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       value,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              busy,
  output logic              ovf
);

  localparam int DISP_W = NIB_W * DIGITS;
  localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [REF_W-1:0]  REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_RST   = ~(DIGITS'(1));

  state_e              state_q, state_d;
  logic [31:0]         last_q, last_d;
  logic [31:0]         bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [DISP_W-1:0]   disp_q, disp_d;
  logic                ovf_q, ovf_d;
  logic                busy_q;
  logic [REF_W-1:0]    ref_q, ref_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic [BCD_W-1:0]    adj_s;
  logic [BCD_W+31:0]   shift_s;
  logic                hi_or_s;
  logic [NIB_W-1:0]    cur_nib_s;
  logic                upper_nz_s;
  logic [6:0]          dec_seg_s;

  assign adj_s   = bcd_add3(bcd_q);
  assign shift_s = {adj_s[BCD_W-2:0], bin_q, 1'b0};

  // Nibbles beyond the physical digit count flag an overflow.
  always_comb begin
    hi_or_s = 1'b0;
    for (int unsigned k = DIGITS; k < BCD_DIGITS; k++) begin
      hi_or_s = hi_or_s | (bcd_q[k*NIB_W +: NIB_W] != 4'd0);
    end
  end

  // Converter FSM: capture on change, 32 shift steps, then one commit cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (value != last_q) begin
          last_d  = value;
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = 6'd0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        bcd_d = shift_s[BCD_W+31:32];
        bin_d = shift_s[31:0];
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_COMMIT: begin
        disp_d  = bcd_q[DISP_W-1:0];
        ovf_d   = hi_or_s;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Refresh divider and digit index.
  always_comb begin
    ref_d = ref_q + REF_W'(1);
    idx_d = idx_q;
    if (ref_q == REF_LAST) begin
      ref_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Select the current nibble and detect any non-zero digit at or above it.
  always_comb begin
    cur_nib_s  = '0;
    upper_nz_s = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      cur_nib_s  = (k == 32'(idx_q)) ? disp_q[k*NIB_W +: NIB_W] : cur_nib_s;
      upper_nz_s = upper_nz_s |
                   ((k >= 32'(idx_q)) && (disp_q[k*NIB_W +: NIB_W] != 4'd0));
    end
  end

  bcd_seg_decode u_dec (
    .nib_i (cur_nib_s),
    .seg_o (dec_seg_s)
  );

  // Overflow dash beats leading-zero blanking, which beats the digit itself.
  always_comb begin
    an_d = ~(DIGITS'(1) << idx_q);
    if (ovf_q) begin
      seg_d = SEG_DASH;
    end else if ((idx_q != '0) && !upper_nz_s) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = dec_seg_s;
    end
  end

  // Converter and display register state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= 6'd0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Scan state and registered segment/anode drive.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ref_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_0;
      an_q  <= AN_RST;
    end else begin
      ref_q <= ref_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule
